// File: rtl/crush_param_ctrl_pkg.sv
// Shared video-effects definitions for the crush parameter controller: FSM states,
// pressure-mapping constants and committed-output reset values.
package crush_param_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StMap,
      StDivReq,
      StDivWait,
      StCommit
   } crush_state_e;

   // Pressure-to-factor mapping constants
   localparam logic [6:0] MapThresh = 7'd25;
   localparam logic [8:0] MapOffset = 9'd49;

   // Committed-output reset values: unity scale and the matching inverse
   localparam logic [7:0] ScaleReset = 8'd255;
   localparam logic [7:0] InvReset   = 8'd16;

   function automatic logic [7:0] sat8(input logic [31:0] value);
      return (value > 32'd255) ? 8'hFF : value[7:0];
   endfunction

endpackage

// File: rtl/crush_scale_map.sv
// Combinational pressure-to-scale-factor mapping; the result is never zero, so it is
// always a safe divisor.
module crush_scale_map
   import crush_param_ctrl_pkg::*;
(
   input  logic [9:0] pressure,
   output logic [7:0] factor,
   output logic       shft
);

   logic [8:0] wide;

   always_comb begin
      wide = 9'd0;
      shft = 1'b0;
      if (pressure[9:8] != 2'b00) begin
         // High range: shift mode, coarse factor from the low byte
         wide = {1'b1, ~pressure[7:0]} >> pressure[9:8];
         shft = 1'b1;
      end else if (pressure[7]) begin
         wide = {4'b0000, ~pressure[6:2]} + MapOffset;
      end else if (pressure[6:0] > MapThresh) begin
         wide = {1'b0, ~pressure[6:0], 1'b0} + MapOffset;
      end else begin
         wide = 9'd255;
      end
      factor = wide[7:0];
   end

endmodule

// File: rtl/crush_param_ctrl.sv
// Per-frame crush parameter update: samples pressure at the vblank trigger, maps it to a
// scale factor, obtains the inverse from an external divider and commits all three atomically.
module crush_param_ctrl
   import crush_param_ctrl_pkg::*;
#(
   parameter logic [10:0] TRIG_H   = 11'd80,
   parameter logic [9:0]  TRIG_V   = 10'd721,
   parameter logic [9:0]  ABORT_V  = 10'd0,
   parameter logic [31:0] DIVIDEND = 32'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] h_count_in,
   input  logic [9:0]  v_count_in,
   input  logic [9:0]  pressure,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   output logic        div_start,
   input  logic        div_busy,
   input  logic [31:0] div_quotient,
   input  logic        div_valid,
   output logic [7:0]  scale_fact,
   output logic [7:0]  inverse_scale_fact,
   output logic        scale_shft,
   output logic        update_pulse,
   output logic        div_timeout
);

   crush_state_e state_q, state_d;

   logic [9:0] pressure_q;
   logic [7:0] stage_factor_q;
   logic       stage_shft_q;
   logic [7:0] stage_inv_q;
   logic [7:0] scale_fact_q;
   logic [7:0] inv_fact_q;
   logic       scale_shft_q;
   logic       timeout_q;

   logic [7:0] map_factor;
   logic       map_shft;

   logic trigger;
   logic abort_line;
   logic capture_en;
   logic map_en;
   logic result_en;
   logic commit_en;
   logic abort_en;

   assign trigger    = (h_count_in == TRIG_H) && (v_count_in == TRIG_V);
   assign abort_line = (v_count_in == ABORT_V);

   crush_scale_map u_scale_map (
      .pressure (pressure_q),
      .factor   (map_factor),
      .shft     (map_shft)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (trigger) state_d = StMap;
         end
         StMap: begin
            state_d = StDivReq;
         end
         StDivReq: begin
            if (abort_line)     state_d = StIdle;
            else if (!div_busy) state_d = StDivWait;
         end
         StDivWait: begin
            if (abort_line)     state_d = StIdle;
            else if (div_valid) state_d = StCommit;
         end
         StCommit: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      capture_en   = 1'b0;
      map_en       = 1'b0;
      result_en    = 1'b0;
      commit_en    = 1'b0;
      abort_en     = 1'b0;
      div_start    = 1'b0;
      update_pulse = 1'b0;
      case (state_q)
         StIdle: begin
            capture_en = trigger;
         end
         StMap: begin
            map_en = 1'b1;
         end
         StDivReq: begin
            // An abort on the same cycle wins; never launch a divide that will be dropped
            abort_en  = abort_line;
            div_start = !abort_line && !div_busy;
         end
         StDivWait: begin
            abort_en  = abort_line;
            result_en = !abort_line && div_valid;
         end
         StCommit: begin
            commit_en    = 1'b1;
            update_pulse = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pressure_q     <= 10'd0;
         stage_factor_q <= 8'd0;
         stage_shft_q   <= 1'b0;
         stage_inv_q    <= 8'd0;
         scale_fact_q   <= ScaleReset;
         inv_fact_q     <= InvReset;
         scale_shft_q   <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         if (capture_en) pressure_q <= pressure;
         if (map_en) begin
            stage_factor_q <= map_factor;
            stage_shft_q   <= map_shft;
         end
         if (result_en) stage_inv_q <= sat8(div_quotient);
         if (commit_en) begin
            scale_fact_q <= stage_factor_q;
            inv_fact_q   <= stage_inv_q;
            scale_shft_q <= stage_shft_q;
         end
         if (abort_en) timeout_q <= 1'b1;
      end
   end

   assign div_dividend       = DIVIDEND;
   assign div_divisor        = {24'd0, stage_factor_q};
   assign scale_fact         = scale_fact_q;
   assign inverse_scale_fact = inv_fact_q;
   assign scale_shft         = scale_shft_q;
   assign div_timeout        = timeout_q;

endmodule
